// File: rtl/wishbone_rr_arbiter_if.sv
// Bus bundle for wishbone_rr_arbiter: flat manager-side signals plus the shared subordinate port.
// The slave modport is the arbiter's view; master is the view of whatever drives the managers and subordinate.
interface wishbone_rr_arbiter_if #(
    parameter int unsigned NUM_MANAGERS = 4
);
    logic [32*NUM_MANAGERS-1:0] A_ADR_I;
    logic [32*NUM_MANAGERS-1:0] A_DAT_I;
    logic [4*NUM_MANAGERS-1:0]  A_SEL_I;
    logic [NUM_MANAGERS-1:0]    A_WE_I;
    logic [NUM_MANAGERS-1:0]    A_STB_I;
    logic [NUM_MANAGERS-1:0]    A_CYC_I;
    logic [32*NUM_MANAGERS-1:0] A_DAT_O;
    logic [NUM_MANAGERS-1:0]    A_ACK_O;
    logic [31:0]                DAT_I;
    logic                       ACK_I;
    logic [31:0]                ADR_O;
    logic [31:0]                DAT_O;
    logic [3:0]                 SEL_O;
    logic                       WE_O;
    logic                       STB_O;
    logic                       CYC_O;
    logic [NUM_MANAGERS-1:0]    GRANT_O;
    logic                       TIMEOUT_O;

    modport slave (
        input  A_ADR_I, A_DAT_I, A_SEL_I, A_WE_I, A_STB_I, A_CYC_I, DAT_I, ACK_I,
        output A_DAT_O, A_ACK_O, ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O, GRANT_O, TIMEOUT_O
    );

    modport master (
        output A_ADR_I, A_DAT_I, A_SEL_I, A_WE_I, A_STB_I, A_CYC_I, DAT_I, ACK_I,
        input  A_DAT_O, A_ACK_O, ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O, GRANT_O, TIMEOUT_O
    );
endinterface

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone subordinate among NUM_MANAGERS managers.
// Define WB_ARB_TIMEOUT_EN to add the watchdog that terminates hung transactions.
module wishbone_rr_arbiter #(
    parameter int unsigned NUM_MANAGERS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hBAD0_BAD0
) (
    input logic                  CLK,
    input logic                  nRST,
    wishbone_rr_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_MANAGERS);
`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_TERM = 2'd2} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_e;
`endif

    state_e                  state_q;
    logic [NUM_MANAGERS-1:0] grant_q;
    logic [IDX_W-1:0]        gidx_q;
    logic [IDX_W-1:0]        rr_ptr_q;
`ifdef WB_ARB_TIMEOUT_EN
    logic [WD_W-1:0]         wd_cnt_q;
    logic                    timeout_q;
`endif

    logic [NUM_MANAGERS-1:0] req_s;
    logic                    pick_vld_s;
    logic [IDX_W-1:0]        pick_idx_s;
    logic                    g_cyc_s;
    logic                    is_term_s;

    logic [31:0] adr_a [NUM_MANAGERS];
    logic [31:0] dat_a [NUM_MANAGERS];
    logic [3:0]  sel_a [NUM_MANAGERS];

    for (genvar i = 0; i < NUM_MANAGERS; i++) begin : g_unpack
        assign adr_a[i] = bus.A_ADR_I[i*32 +: 32];
        assign dat_a[i] = bus.A_DAT_I[i*32 +: 32];
        assign sel_a[i] = bus.A_SEL_I[i*4 +: 4];
    end

    assign req_s   = bus.A_STB_I & bus.A_CYC_I;
    assign g_cyc_s = bus.A_CYC_I[gidx_q];

    // First requester after ptr (wrapping), so manager ptr itself is searched last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_MANAGERS-1:0] req,
                                               input logic [IDX_W-1:0]        ptr);
        logic [IDX_W:0] res;
        int unsigned    cand;
        res = '0;
        for (int off = NUM_MANAGERS; off >= 1; off--) begin
            cand = 32'(ptr) + 32'(off);
            if (cand >= NUM_MANAGERS) begin
                cand = cand - NUM_MANAGERS;
            end else begin
                cand = cand;
            end
            if (req[cand[IDX_W-1:0]]) begin
                res = {1'b1, cand[IDX_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin winner among current requesters.
    always_comb begin
        {pick_vld_s, pick_idx_s} = rr_pick(req_s, rr_ptr_q);
    end

`ifdef WB_ARB_TIMEOUT_EN
    assign is_term_s     = (state_q == ST_TERM);
    assign bus.TIMEOUT_O = timeout_q;
`else
    assign is_term_s     = 1'b0;
    assign bus.TIMEOUT_O = 1'b0;
`endif
    assign bus.GRANT_O = grant_q;

    // Arbitration FSM: grant selection, release on ACK or CYC drop, watchdog termination.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= IDX_W'(NUM_MANAGERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_q <= ST_GRANT;
                        grant_q <= NUM_MANAGERS'(1) << pick_idx_s;
                        gidx_q  <= pick_idx_s;
`ifdef WB_ARB_TIMEOUT_EN
                        wd_cnt_q <= '0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // An abort (CYC low) and an ACK both release the bus the same way.
                    if (!g_cyc_s || bus.ACK_I) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= gidx_q;
`ifdef WB_ARB_TIMEOUT_EN
                    end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= ST_TERM;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
`else
                    end else begin
                        state_q <= ST_GRANT;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ST_TERM: begin
                    state_q  <= ST_IDLE;
                    grant_q  <= '0;
                    rr_ptr_q <= gidx_q;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Subordinate side follows the granted manager only while in GRANT.
    always_comb begin
        bus.ADR_O = 32'h0;
        bus.DAT_O = 32'h0;
        bus.SEL_O = 4'h0;
        bus.WE_O  = 1'b0;
        bus.STB_O = 1'b0;
        bus.CYC_O = 1'b0;
        case (state_q)
            ST_GRANT: begin
                bus.ADR_O = adr_a[gidx_q];
                bus.DAT_O = dat_a[gidx_q];
                bus.SEL_O = sel_a[gidx_q];
                bus.WE_O  = bus.A_WE_I[gidx_q];
                bus.STB_O = bus.A_STB_I[gidx_q];
                bus.CYC_O = bus.A_CYC_I[gidx_q];
            end
            default: begin
                bus.CYC_O = 1'b0;
            end
        endcase
    end

    // Manager side: only the granted manager sees data/ack; a terminated one gets TIMEOUT_DATA.
    always_comb begin
        bus.A_DAT_O = '0;
        bus.A_ACK_O = '0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (grant_q[i] && (state_q == ST_GRANT)) begin
                bus.A_DAT_O[i*32 +: 32] = bus.DAT_I;
                bus.A_ACK_O[i]          = bus.ACK_I & bus.A_CYC_I[i];
            end else if (grant_q[i] && is_term_s) begin
                bus.A_DAT_O[i*32 +: 32] = TIMEOUT_DATA;
                bus.A_ACK_O[i]          = 1'b1;
            end else begin
                bus.A_DAT_O[i*32 +: 32] = 32'h0;
                bus.A_ACK_O[i]          = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Self-checking bench for wishbone_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model of the arbitration rules.
module tb_wishbone_rr_arbiter;
    localparam int          N     = 4;
    localparam int          T     = 8;
    localparam logic [31:0] TO_DATA = 32'hBAD0_BAD0;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: granted manager (-1 when idle), last served manager, watchdog.
    int m_g   = -1;
    int m_ptr = N - 1;
    int m_wd  = 0;
    bit m_term = 1'b0;

    wishbone_rr_arbiter_if #(.NUM_MANAGERS(N)) bus ();

    wishbone_rr_arbiter #(
        .NUM_MANAGERS  (N),
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_DATA  (TO_DATA)
    ) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   req;
        logic         ack;
        logic [31:0]  dat;
        logic [3:0]   e_grant;
        logic [3:0]   e_ack;
        logic         e_stb;
        logic [127:0] e_adat;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_outputs(output logic [131:0] mgr, output logic [70:0] sub,
                                          output logic [3:0] g, output logic to);
        mgr = '0;
        sub = '0;
        g   = '0;
        to  = 1'b0;
        if (m_g >= 0) begin
            g = 4'(1 << m_g);
            if (m_term) begin
                mgr[m_g*32 +: 32] = TO_DATA;
                mgr[128 + m_g]    = 1'b1;
                to                = 1'b1;
            end else begin
                sub = {bus.A_ADR_I[m_g*32 +: 32], bus.A_DAT_I[m_g*32 +: 32], bus.A_SEL_I[m_g*4 +: 4],
                       bus.A_WE_I[m_g], bus.A_STB_I[m_g], bus.A_CYC_I[m_g]};
                mgr[m_g*32 +: 32] = bus.DAT_I;
                mgr[128 + m_g]    = bus.ACK_I & bus.A_CYC_I[m_g];
            end
        end
    endfunction

    task automatic model_update();
        logic [3:0] req;
        req = bus.A_STB_I & bus.A_CYC_I;
        if (!nrst) begin
            m_g = -1; m_ptr = N - 1; m_wd = 0; m_term = 1'b0;
        end else if (m_term) begin
            m_ptr = m_g; m_g = -1; m_term = 1'b0;
        end else if (m_g < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_g  = (m_ptr + k) % N;
                    m_wd = 0;
                    break;
                end
            end
        end else if (!bus.A_CYC_I[m_g] || bus.ACK_I) begin
            m_ptr = m_g; m_g = -1;
        end else if (TO_EN && m_wd == T - 1) begin
            m_term = 1'b1;
        end else begin
            m_wd++;
        end
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic tick(input string tag);
        logic [131:0] e_mgr;
        logic [70:0]  e_sub;
        logic [3:0]   e_g;
        logic         e_to;
        #1;
        model_outputs(e_mgr, e_sub, e_g, e_to);
        chk({tag, ".grant"}, bus.GRANT_O, e_g);
        chk({tag, ".timeout"}, bus.TIMEOUT_O, e_to);
        chk({tag, ".sub"}, {bus.ADR_O, bus.DAT_O, bus.SEL_O, bus.WE_O, bus.STB_O, bus.CYC_O}, e_sub);
        chk({tag, ".mgr"}, {bus.A_ACK_O, bus.A_DAT_O}, e_mgr);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        bus.A_STB_I = r;
        bus.A_CYC_I = r;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        set_req(4'b0000);
        bus.ACK_I = 1'b0;
        bus.DAT_I = 32'h0;
        tick("rst");
        nrst = 1'b1;
    endtask

    initial begin
        vec_t         tbl [13];
        int           order[$];
        logic [3:0]   prev_g;
        int           exp_order [5];
        bit           seen;
        int           gcnt;

        tbl[0]  = '{4'b0101, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 128'h0};
        tbl[1]  = '{4'b0101, 1'b1, 32'h0,         4'b0001, 4'b0001, 1'b1, 128'h0};
        tbl[2]  = '{4'b0100, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 128'h0};
        tbl[3]  = '{4'b0100, 1'b1, 32'h0,         4'b0100, 4'b0100, 1'b1, 128'h0};
        tbl[4]  = '{4'b0101, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 128'h0};
        tbl[5]  = '{4'b0101, 1'b0, 32'h0,         4'b0001, 4'b0000, 1'b1, 128'h0};
        tbl[6]  = '{4'b0101, 1'b1, 32'h0,         4'b0001, 4'b0001, 1'b1, 128'h0};
        tbl[7]  = '{4'b0100, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 128'h0};
        tbl[8]  = '{4'b0100, 1'b0, 32'h0,         4'b0100, 4'b0000, 1'b1, 128'h0};
        tbl[9]  = '{4'b0000, 1'b1, 32'h0,         4'b0100, 4'b0000, 1'b0, 128'h0};
        tbl[10] = '{4'b0010, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 128'h0};
        tbl[11] = '{4'b0010, 1'b1, 32'h1234_5678, 4'b0010, 4'b0010, 1'b1,
                    {32'h0, 32'h0, 32'h1234_5678, 32'h0}};
        tbl[12] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 128'h0};
        exp_order = '{1, 2, 4, 8, 1};

        nrst = 1'b0;
        bus.A_WE_I = 4'b0000;
        set_req(4'b0000);
        bus.ACK_I = 1'b0;
        bus.DAT_I = 32'h0;
        for (int i = 0; i < N; i++) begin
            bus.A_ADR_I[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            bus.A_DAT_I[i*32 +: 32] = 32'hD000_0000 + 32'(i);
            bus.A_SEL_I[i*4 +: 4]   = 4'hF;
        end
        @(posedge clk);
        model_update();
        #1;

        // Idle after reset: everything zero for 10 cycles.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("idle.all", {bus.GRANT_O, bus.TIMEOUT_O, bus.STB_O, bus.CYC_O, bus.ADR_O,
                             bus.A_ACK_O, bus.A_DAT_O}, 256'h0);
            tick("idle");
        end

        // Vector table: 0/2 round robin, read data routing, abort without ACK.
        do_reset();
        for (int r = 0; r < 13; r++) begin
            set_req(tbl[r].req);
            bus.ACK_I = tbl[r].ack;
            bus.DAT_I = tbl[r].dat;
            #1;
            chk($sformatf("tbl%0d.grant", r), bus.GRANT_O, tbl[r].e_grant);
            chk($sformatf("tbl%0d.ack", r), bus.A_ACK_O, tbl[r].e_ack);
            chk($sformatf("tbl%0d.stb", r), bus.STB_O, tbl[r].e_stb);
            chk($sformatf("tbl%0d.adat", r), bus.A_DAT_O, tbl[r].e_adat);
            tick("tbl");
        end

        // All four request continuously, ack on the second GRANT cycle.
        do_reset();
        set_req(4'b1111);
        prev_g = 4'b0000;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            if (bus.GRANT_O != 4'b0000 && bus.GRANT_O != prev_g) begin
                order.push_back(int'(bus.GRANT_O));
                bus.ACK_I = 1'b0;
            end else if (bus.GRANT_O != 4'b0000) begin
                bus.ACK_I = 1'b1;
            end else begin
                bus.ACK_I = 1'b0;
            end
            prev_g = bus.GRANT_O;
            tick("rr");
        end
        chk("rr.count", order.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr.order%0d", i), (i < order.size()) ? order[i] : 0, exp_order[i]);
        end

        // Reset while a grant is held forces idle with no ACK.
        do_reset();
        set_req(4'b0010);
        tick("mrst");
        chk("mrst.granted", bus.GRANT_O, 4'b0010);
        nrst = 1'b0;
        tick("mrst");
        chk("mrst.grant", bus.GRANT_O, 4'b0000);
        chk("mrst.ack", bus.A_ACK_O, 4'b0000);
        nrst = 1'b1;
        set_req(4'b0000);
        tick("mrst");

        // Subordinate never acks manager 3.
        do_reset();
        set_req(4'b1000);
        seen = 1'b0;
        gcnt = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            #1;
            if (bus.TIMEOUT_O) begin
                seen = 1'b1;
                chk("to.dat", bus.A_DAT_O[127:96], TO_DATA);
                chk("to.ack", bus.A_ACK_O, 4'b1000);
                set_req(4'b0000);
            end else if (bus.GRANT_O == 4'b1000) begin
                gcnt++;
            end
            tick("to");
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("to.seen", seen, 1'b1);
        chk("to.grant_cycles", gcnt, T);
`else
        chk("to.seen", seen, 1'b0);
        chk("to.held", bus.GRANT_O, 4'b1000);
`endif
        set_req(4'b0000);
        tick("to");
        tick("to");

        // Randomized traffic with occasional resets, checked by the model.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.A_ADR_I[i*32 +: 32] = $urandom;
                bus.A_DAT_I[i*32 +: 32] = $urandom;
                bus.A_SEL_I[i*4 +: 4]   = 4'($urandom_range(0, 15));
            end
            bus.A_WE_I  = 4'($urandom);
            bus.A_STB_I = 4'($urandom);
            bus.A_CYC_I = bus.A_STB_I | 4'($urandom & $urandom);
            bus.ACK_I   = ($urandom_range(0, 3) == 0);
            bus.DAT_I   = $urandom;
            nrst        = ($urandom_range(0, 59) != 0);
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
